// File: rtl/pipeline_drain_if.sv
// Handshake bundle between the last pipeline stage, the drain FIFO and the
// downstream consumer.
//   in_data / in_valid : word from the pipeline (no ready; taken or dropped)
//   stall              : registered back-pressure toward the pipeline
//   out_data/out_valid : head-of-FIFO word presented to the consumer
//   out_ready          : consumer accepts out_data this cycle
// master = pipeline/consumer side, slave = drain FIFO side.
interface pipeline_drain_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             stall;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  stall, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output stall, out_data, out_valid
    );
endinterface

// File: rtl/pipeline_drain.sv
// pipeline_drain: receiving end of the stall/valid pipeline interface.
// Buffers one word per cycle from the last pipeline stage in a DEPTH-entry
// FIFO and drains it to a consumer over valid/ready. Raises a registered
// stall once occupancy reaches DEPTH - STALL_SLACK so the words already in
// flight still fit. A word arriving while full (and not popped) is dropped
// and sets a sticky overflow flag.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high clear of all state
//   bus      : pipeline_drain_if.slave (in_data/in_valid/stall,
//              out_data/out_valid/out_ready)
//   flush    : synchronous discard of all buffered words (wins over push/pop)
//   count    : current occupancy, 0..DEPTH
//   overflow : sticky, set when a valid word was dropped; cleared by reset
module pipeline_drain #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int STALL_SLACK = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    pipeline_drain_if.slave            bus,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(DEPTH - STALL_SLACK);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;

    logic pop;
    logic push;
    logic drop;
    logic full;
    logic wr_en;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        full = (count_q == FULL_C);
        pop  = out_valid_q && bus.out_ready;
        // A full FIFO still accepts a word when the head leaves this cycle.
        push = bus.in_valid && (!full || pop);
        drop = bus.in_valid && full && !pop;

        if (flush) begin
            // Flush wins: the coincident word is discarded without counting
            // as an overflow and the coincident pop does not complete.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end

        out_valid_d = (count_d != '0);
        // Stall is decided on next-cycle occupancy so it rises on the same
        // edge that makes count reach the threshold.
        stall_d     = (count_d >= THRESH_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its _d value from before the edge.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are only
    // observable through out_data, which is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.out_data  = out_valid_q ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.stall     = stall_q;
    assign count         = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_pipeline_drain.sv
// Directed self-checking bench for pipeline_drain (WIDTH=32, DEPTH=8,
// STALL_SLACK=2, stall threshold 6).
module tb_pipeline_drain;
    logic       clk;
    logic       reset;
    logic       flush;
    logic [3:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_drain_if #(.WIDTH(32)) bus ();

    pipeline_drain #(
        .WIDTH      (32),
        .DEPTH      (8),
        .STALL_SLACK(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flush   (flush),
        .count   (count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Called at the sample point; asserts reset between edges and checks
    // that state clears without a clock edge.
    task automatic async_reset(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check({tag, "_count"},     count,         64'd0);
        check({tag, "_out_valid"}, bus.out_valid, 64'd0);
        check({tag, "_stall"},     bus.stall,     64'd0);
        check({tag, "_overflow"},  overflow,      64'd0);
        #2 reset = 1'b0;
        step();
    endtask

    logic [31:0] model_q[$];
    int          sent;
    int          received;
    int          cycles;
    logic        stall_seen;
    logic        model_ovf;
    logic        do_pop;
    logic        do_push;

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // ---------------- Reset values ----------------
        #3;
        check("rst_count",     count,         64'd0);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_stall",     bus.stall,     64'd0);
        check("rst_overflow",  overflow,      64'd0);
        check("rst_out_data",  bus.out_data,  64'd0);
        #9 reset = 1'b0;
        step();

        // ---------------- Single word ----------------
        bus.out_ready = 1'b1;
        push_word(32'hA5A5_0001);
        check("single_valid", bus.out_valid, 64'd1);
        check("single_data",  bus.out_data,  64'hA5A5_0001);
        check("single_count", count,         64'd1);
        step();
        check("single_count_after", count,         64'd0);
        check("single_valid_after", bus.out_valid, 64'd0);

        // ---------------- Fill and stall ----------------
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'h10 + i);
        check("fill5_stall", bus.stall, 64'd0);
        push_word(32'h15);
        check("fill6_count", count,     64'd6);
        check("fill6_stall", bus.stall, 64'd1);
        push_word(32'h16);
        push_word(32'h17);
        check("fill8_count",    count,    64'd8);
        check("fill8_overflow", overflow, 64'd0);
        push_word(32'h18);
        check("drop_count",    count,    64'd8);
        check("drop_overflow", overflow, 64'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_data%0d", k), bus.out_data, 64'h10 + k);
            step();
            if (k == 1) check("drain_stall_at6", bus.stall, 64'd1);
            if (k == 2) check("drain_stall_at5", bus.stall, 64'd0);
        end
        check("drain_empty",    bus.out_valid, 64'd0);
        check("drain_overflow", overflow,      64'd1);

        // ---------------- Asynchronous reset at count 5 ----------------
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'h50 + i);
        check("pre_reset_count", count, 64'd5);
        async_reset("areset");

        // ---------------- Full push+pop ----------------
        for (int i = 0; i < 8; i++) push_word(32'h90 + i);
        check("fullpp_pre_count", count, 64'd8);
        check("fullpp_head",      bus.out_data, 64'h90);
        bus.out_ready = 1'b1;
        push_word(32'h99);
        check("fullpp_count",    count,    64'd8);
        check("fullpp_overflow", overflow, 64'd0);
        for (int k = 1; k < 8; k++) begin
            check($sformatf("fullpp_data%0d", k), bus.out_data, 64'h90 + k);
            step();
        end
        check("fullpp_last", bus.out_data, 64'h99);
        step();
        check("fullpp_empty", count, 64'd0);

        // ---------------- Flush ----------------
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_word(32'h30 + i);
        check("flush_pre_overflow", overflow, 64'd1);
        bus.out_ready = 1'b1;
        step(); step(); step();
        check("flush_pre_count", count, 64'd5);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_count",     count,         64'd0);
        check("flush_out_valid", bus.out_valid, 64'd0);
        check("flush_stall",     bus.stall,     64'd0);
        check("flush_overflow",  overflow,      64'd1);
        bus.out_ready = 1'b0;
        push_word(32'h77);
        check("flush_next_data",  bus.out_data, 64'h77);
        check("flush_next_count", count,        64'd1);
        bus.out_ready = 1'b1;
        step();
        check("flush_next_alone", bus.out_valid, 64'd0);

        // ---------------- Pointer wrap with compliant producer ----------------
        async_reset("areset2");
        sent       = 0;
        received   = 0;
        cycles     = 0;
        stall_seen = 1'b0;
        model_ovf  = 1'b0;
        model_q.delete();
        while (received < 20 && cycles < 200) begin
            check($sformatf("wrap_count_c%0d", cycles), count, 64'(model_q.size()));
            // The producer reacts to the stall it saw one cycle earlier.
            bus.in_valid  = (sent < 20) && !stall_seen;
            bus.in_data   = 32'h200 + sent;
            bus.out_ready = (cycles % 2) == 0;
            stall_seen    = bus.stall;
            do_pop  = bus.out_ready && (model_q.size() != 0);
            do_push = bus.in_valid && (model_q.size() < 8 || do_pop);
            if (bus.in_valid && !do_push) model_ovf = 1'b1;
            if (do_pop) begin
                check($sformatf("wrap_data%0d", received), bus.out_data, 64'(model_q.pop_front()));
                received++;
            end
            if (do_push) model_q.push_back(bus.in_data);
            if (bus.in_valid) sent++;
            step();
            cycles++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("wrap_received", 64'(received), 64'd20);
        check("wrap_overflow", overflow,      64'(model_ovf));
        check("wrap_final_count", count,      64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_drain.md
# pipeline_drain

Receiving end of the `stall`/valid interface that the pipeline stages drive. Accepts one word per cycle from the last pipeline stage into a small FIFO and drains it to a consumer over a valid/ready handshake. Generates the registered `stall` back-pressure toward the pipeline early enough to absorb the words already in flight when stall is raised. Reports a sticky error if a word arrives with no room.

## Interface
- `WIDTH`, 32: data word width.
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `STALL_SLACK`, 2: entries reserved for in-flight words. Stall threshold is `DEPTH - STALL_SLACK`; legal range is 1 to `DEPTH-1`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_data` in WIDTH: word from the pipeline.
- `in_valid` in 1: `in_data` is valid this cycle. No ready is returned; the word must be taken or dropped.
- `flush` in 1: synchronous discard of all buffered words.
- `stall` out 1: registered back-pressure to the pipeline.
- `out_data` out WIDTH: head-of-FIFO word.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `count` out $clog2(DEPTH+1): current occupancy.
- `overflow` out 1: sticky; a valid input word was dropped.

## Operation
- Storage: `DEPTH` x `WIDTH` array with read and write pointers of width log2(DEPTH). Pointers wrap modulo DEPTH.
- Pop = `out_valid && out_ready`.
- Push = `in_valid && (count < DEPTH || pop)`. A push while full is legal when a pop occurs in the same cycle.
- Drop = `in_valid && count == DEPTH && !pop`:
  - word discarded, `overflow` set to 1;
  - `count` and pointers unchanged.
- Count update:
  - push and pop together: count unchanged;
  - push only: +1;
  - pop only: -1.
- `out_valid` = (`count != 0`). `out_data` = mem[rd_ptr] (show-ahead). `out_data` is don't-care when `out_valid` is 0.
- `stall` register: next value = (count_next >= `DEPTH - STALL_SLACK`), where count_next is the occupancy after this cycle's push/pop/flush.
- Flush has priority over push, pop and drop in the same cycle:
  - count and both pointers go to 0;
  - a coincident `in_valid` word is discarded and does not set `overflow`;
  - the coincident pop does not complete; the consumer sees `out_valid` = 0 next cycle.
- `overflow` is cleared only by `reset`; `flush` does not clear it.
- FIFO order is strict; words are never reordered or duplicated.

## Timing
- Reset values: `stall` 0, `out_valid` 0, `count` 0, `overflow` 0, pointers 0. `out_data` is don't-care, and the implementation drives 0.
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass, even when the FIFO is empty.
- `stall` changes one edge after the occupancy crosses the threshold in either direction. The producer reacts one more cycle later. Therefore up to `STALL_SLACK` words may arrive after the threshold is reached, and no drop occurs with a compliant producer.
- `count`, `out_valid` and `overflow` update on the same edge as the push/pop that caused them.
- Reset asserted mid-operation clears all state asynchronously, regardless of `clk`. The first push may occur on the first rising edge after `reset` is released.

## Test plan
Defaults for all scenarios: `DEPTH`=8, `STALL_SLACK`=2, threshold 6.

- **Reset:** assert `reset` asynchronously between clock edges while `count`=5 -> immediately `count`=0, `out_valid`=0, `stall`=0, `overflow`=0.
- **Single word:** `out_ready`=1; push 0xA5A5_0001 at edge 0 -> cycle 1: `out_valid`=1, `out_data`=0xA5A5_0001, `count`=1. After edge 1: `count`=0, `out_valid`=0.
- **Fill and stall:** `out_ready`=0; push 0x10..0x15 (6 words) -> `count`=6 after the 6th edge and `stall`=1 in the same cycle. Push 0x16 and 0x17 -> `count`=8, `overflow`=0. Push 0x18 -> dropped, `overflow`=1, `count`=8. Drain with `out_ready`=1 -> outputs 0x10..0x17 in order. `stall` falls to 0 after the edge where `count` drops to 5.
- **Full push+pop:** `count`=8, `in_valid`=1 with 0x99 and `out_ready`=1 -> `count` stays 8, `overflow` stays 0, 0x99 emerges 8th.
- **Flush:** `count`=5, `flush`=1 with `in_valid`=1 and `out_ready`=1 in the same cycle -> next cycle `count`=0, `out_valid`=0, `stall`=0. Previously set `overflow` is retained. The next pushed word appears alone.
- **Pointer wrap:** stream 20 words 0x200..0x213 with `out_ready` toggling 1,0,1,0 -> output sequence exact, no drops, `count` never exceeds 8.
